// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared LC2K opcodes, halt encoding and instruction-memory state type
package lc2k_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NOR  = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_SW   = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_JALR = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;
   localparam logic [2:0] OP_NOOP = 3'd7;

   localparam logic [31:0] HALT_WORD = 32'h0180_0000;

   typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} imem_state_t;

endpackage

// File: rtl/lc2k_imem_ram.sv
// lc2k_imem_ram: single-port synchronous RAM with write enable and registered read
module lc2k_imem_ram
   import lc2k_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // write on enable, read address registered every cycle
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      o_rdata <= r_mem[i_addr];
   end

endmodule

// File: rtl/lc2k_imem_loadable.sv
// lc2k_imem_loadable: run-time loadable LC2K instruction memory with latency-configurable fetch port
module lc2k_imem_loadable
   import lc2k_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int ADDR_W   = 6,
   parameter int READ_LAT = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_load_start,
   input  logic            i_load_valid,
   output logic            o_load_ready,
   input  logic [31:0]     i_load_data,
   input  logic            i_load_last,
   output logic [ADDR_W:0] o_prog_len,
   output logic            o_running,
   input  logic            i_fetch_req,
   output logic            o_fetch_ready,
   input  logic [31:0]     i_fetch_pc,
   output logic            o_fetch_valid,
   output logic [31:0]     o_fetch_instr,
   output logic            o_fetch_fault
);

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] LP_LAST  = LP_DEPTH - LP_ONE;

   imem_state_t       r_state, w_state_nx;
   logic [ADDR_W:0]   r_wr_ptr, r_prog_len;
   logic [ADDR_W-1:0] w_addr;
   logic              w_load_hs, w_accept, w_fault, w_in_flight, w_valid, w_flt;
   logic              r_v1, r_v2, r_f1, r_f2;
   logic [31:0]       w_rdata, r_rd2, w_data, w_resp, r_hold;

   assign o_load_ready  = (r_state == LOAD) && (r_wr_ptr < LP_DEPTH);
   assign w_load_hs     = o_load_ready && i_load_valid && !i_load_start;
   assign o_running     = r_state == RUN;
   assign o_fetch_ready = o_running && !i_load_start;
   assign w_accept      = i_fetch_req && o_fetch_ready;
   assign w_fault       = i_fetch_pc >= 32'(r_prog_len);
   assign w_addr        = (r_state == LOAD) ? r_wr_ptr[ADDR_W-1:0] : i_fetch_pc[ADDR_W-1:0];
   assign w_valid       = (READ_LAT == 2) ? r_v2 : r_v1;
   assign w_flt         = (READ_LAT == 2) ? r_f2 : r_f1;
   assign w_data        = (READ_LAT == 2) ? r_rd2 : w_rdata;
   assign w_in_flight   = r_v1 || ((READ_LAT == 2) && r_v2);
   assign w_resp        = w_flt ? HALT_WORD : w_data;
   assign o_prog_len    = r_prog_len;
   assign o_fetch_valid = w_valid;
   assign o_fetch_fault = w_valid && w_flt;
   assign o_fetch_instr = w_valid ? w_resp : r_hold;

   lc2k_imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_load_hs),
      .i_addr  (w_addr),
      .i_wdata (i_load_data),
      .o_rdata (w_rdata)
   );

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= EMPTY;
      else          r_state <= w_state_nx;
   end

   // next state: load until last/full word, drain in-flight fetches before reloading
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         EMPTY:   if (i_load_start) w_state_nx = LOAD;
         LOAD:    if (w_load_hs && (i_load_last || r_wr_ptr == LP_LAST)) w_state_nx = RUN;
         RUN:     if (i_load_start) w_state_nx = DRAIN;
         DRAIN:   if (!w_in_flight) w_state_nx = LOAD;
         default: w_state_nx = EMPTY;
      endcase
   end

   // write pointer and program length
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_prog_len <= '0;
      end else begin
         r_wr_ptr <= (r_state == DRAIN || (r_state == LOAD && i_load_start)) ? '0 : r_wr_ptr + (ADDR_W+1)'(w_load_hs);
         if (r_state == DRAIN && !w_in_flight) r_prog_len <= '0;
         else if (w_load_hs && w_state_nx == RUN) r_prog_len <= r_wr_ptr + LP_ONE;
      end
   end

   // response pipeline: valid and fault flags per stage, last response held
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_f1   <= 1'b0;
         r_f2   <= 1'b0;
         r_hold <= '0;
      end else begin
         r_v1 <= w_accept;
         r_f1 <= w_fault;
         r_v2 <= r_v1;
         r_f2 <= r_f1;
         if (w_valid) r_hold <= w_resp;
      end
   end

   // second data stage used when the read latency is two cycles
   always_ff @(posedge i_clk) begin
      r_rd2 <= w_rdata;
   end

endmodule

// File: tb/tb_lc2k_imem_loadable.sv
// tb_lc2k_imem_loadable: two DUTs (read latency 1 and 2) checked against a behavioural memory model
module tb_lc2k_imem_loadable;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam logic [31:0] HALT = 32'h0180_0000;
   localparam int S_EMPTY = 0, S_LOAD = 1, S_RUN = 2, S_DRAIN = 3;

   logic clk = 1'b0, rst_n = 1'b1;
   logic load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0, fetch_req = 1'b0;
   logic [31:0] load_data = '0, fetch_pc = '0;
   logic [1:0] load_ready, running, fetch_ready, fetch_valid, fetch_fault;
   logic [ADDR_W:0] prog_len [2];
   logic [31:0] fetch_instr [2];

   int n_chk = 0, n_err = 0, cyc = 0;
   int m_st [2], m_ptr [2], m_len [2];
   logic [31:0] m_mem [2][DEPTH];
   logic [31:0] m_hold [2];
   bit e_v [2][4096];
   bit e_f [2][4096];
   logic [31:0] e_d [2][4096];

   logic [31:0] subone [12] = '{32'd8454158, 32'd8519694, 32'd655362, 32'd16842751, 32'd19136515,
                                32'd16842751, 32'd16842751, 32'd29360128, 32'd13238272, 32'd29360128,
                                32'd25165824, 32'd5};
   logic [31:0] jalr [7] = '{32'd8454150, 32'd23527424, 32'd29360128, 32'd655361, 32'd29360128,
                             32'd29360128, 32'd25165824};

   always #5 clk = ~clk;

   lc2k_imem_loadable #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start), .i_load_valid(load_valid),
      .o_load_ready(load_ready[0]), .i_load_data(load_data), .i_load_last(load_last),
      .o_prog_len(prog_len[0]), .o_running(running[0]), .i_fetch_req(fetch_req),
      .o_fetch_ready(fetch_ready[0]), .i_fetch_pc(fetch_pc), .o_fetch_valid(fetch_valid[0]),
      .o_fetch_instr(fetch_instr[0]), .o_fetch_fault(fetch_fault[0])
   );

   lc2k_imem_loadable #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(2)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start), .i_load_valid(load_valid),
      .o_load_ready(load_ready[1]), .i_load_data(load_data), .i_load_last(load_last),
      .o_prog_len(prog_len[1]), .o_running(running[1]), .i_fetch_req(fetch_req),
      .o_fetch_ready(fetch_ready[1]), .i_fetch_pc(fetch_pc), .o_fetch_valid(fetch_valid[1]),
      .o_fetch_instr(fetch_instr[1]), .o_fetch_fault(fetch_fault[1])
   );

   task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s lat%0d got %h expected %h at cycle %0d", nm, i + 1, got, exp, cyc);
      end
   endtask

   // model: instance i answers a fetch accepted at edge k during cycle k+i
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_st[i] = S_EMPTY;
            m_ptr[i] = 0;
            m_len[i] = 0;
            m_hold[i] = '0;
            for (int j = 1; j < 4; j++) e_v[i][cyc + j] = 1'b0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            case (m_st[i])
               S_EMPTY: if (load_start) begin m_st[i] = S_LOAD; m_ptr[i] = 0; end
               S_LOAD:
                  if (load_start) m_ptr[i] = 0;
                  else if (load_valid && m_ptr[i] < DEPTH) begin
                     m_mem[i][m_ptr[i]] = load_data;
                     m_ptr[i]++;
                     if (load_last || m_ptr[i] == DEPTH) begin m_len[i] = m_ptr[i]; m_st[i] = S_RUN; end
                  end
               S_RUN:
                  if (load_start) m_st[i] = S_DRAIN;
                  else if (fetch_req) begin
                     e_v[i][cyc + i] = 1'b1;
                     e_f[i][cyc + i] = fetch_pc >= 32'(m_len[i]);
                     e_d[i][cyc + i] = (fetch_pc >= 32'(m_len[i])) ? HALT : m_mem[i][fetch_pc % DEPTH];
                  end
               S_DRAIN:
                  if (!(e_v[i][cyc - 1] || e_v[i][cyc])) begin m_st[i] = S_LOAD; m_ptr[i] = 0; m_len[i] = 0; end
               default: ;
            endcase
         end
      end
   end

   // compare every output of both instances each cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            chk("load_ready", i, 32'(load_ready[i]), 32'(m_st[i] == S_LOAD && m_ptr[i] < DEPTH));
            chk("running", i, 32'(running[i]), 32'(m_st[i] == S_RUN));
            chk("prog_len", i, 32'(prog_len[i]), 32'(m_len[i]));
            chk("fetch_ready", i, 32'(fetch_ready[i]), 32'(m_st[i] == S_RUN && !load_start));
            chk("fetch_valid", i, 32'(fetch_valid[i]), 32'(e_v[i][cyc]));
            chk("fetch_fault", i, 32'(fetch_fault[i]), 32'(e_v[i][cyc] && e_f[i][cyc]));
            chk("fetch_instr", i, fetch_instr[i], e_v[i][cyc] ? e_d[i][cyc] : m_hold[i]);
            if (e_v[i][cyc]) m_hold[i] = e_d[i][cyc];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1; tick(); load_start = 1'b0;
      repeat (4) tick();
      load_start = 1'b1; tick(); load_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      load_valid = 1'b1; load_data = d; load_last = last;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc);
      fetch_req = 1'b1; fetch_pc = pc;
      tick();
      fetch_req = 1'b0;
   endtask

   task automatic rst_checks();
      for (int i = 0; i < 2; i++) begin
         chk("rst_load_ready", i, 32'(load_ready[i]), 32'd0);
         chk("rst_running", i, 32'(running[i]), 32'd0);
         chk("rst_fetch_ready", i, 32'(fetch_ready[i]), 32'd0);
         chk("rst_fetch_valid", i, 32'(fetch_valid[i]), 32'd0);
         chk("rst_fetch_fault", i, 32'(fetch_fault[i]), 32'd0);
         chk("rst_fetch_instr", i, fetch_instr[i], 32'd0);
         chk("rst_prog_len", i, 32'(prog_len[i]), 32'd0);
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 rst_checks();
      tick();
      rst_n = 1'b1;
      fetch_req = 1'b1; fetch_pc = '0;
      repeat (10) tick();
      for (int i = 0; i < 2; i++) chk("empty_fetch_ready", i, 32'(fetch_ready[i]), 32'd0);
      fetch_req = 1'b0;
      start_load();
      for (int k = 0; k < 12; k++) send(subone[k], k == 11);
      for (int i = 0; i < 2; i++) begin
         chk("subone_len", i, 32'(prog_len[i]), 32'd12);
         chk("subone_running", i, 32'(running[i]), 32'd1);
      end
      for (int k = 0; k < 12; k++) fetch(32'(k));
      fetch(32'd12);
      fetch(32'h0001_0000);
      repeat (3) tick();
      fetch(32'd0);
      chk("pc0_instr", 0, fetch_instr[0], 32'd8454158);
      tick();
      chk("pc0_instr", 1, fetch_instr[1], 32'd8454158);
      fetch(32'd12);
      chk("pc12_instr", 0, fetch_instr[0], HALT);
      chk("pc12_fault", 0, 32'(fetch_fault[0]), 32'd1);
      tick();
      chk("pc12_instr", 1, fetch_instr[1], HALT);
      chk("pc12_fault", 1, 32'(fetch_fault[1]), 32'd1);
      repeat (2) tick();
      start_load();
      for (int k = 0; k < DEPTH + 3; k++) send(32'hA000_0000 + 32'(k), 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("full_len", i, 32'(prog_len[i]), 32'd16);
         chk("full_running", i, 32'(running[i]), 32'd1);
         chk("full_load_ready", i, 32'(load_ready[i]), 32'd0);
      end
      for (int k = 0; k < DEPTH; k++) fetch(32'(k));
      repeat (3) tick();
      fetch(32'd0); fetch(32'd1); fetch(32'd2);
      load_start = 1'b1; fetch_req = 1'b1; fetch_pc = 32'd3;
      #1;
      for (int i = 0; i < 2; i++) chk("drain_fetch_ready", i, 32'(fetch_ready[i]), 32'd0);
      tick();
      load_start = 1'b0; fetch_req = 1'b0;
      repeat (5) tick();
      for (int i = 0; i < 2; i++) begin
         chk("drain_len", i, 32'(prog_len[i]), 32'd0);
         chk("drain_load_ready", i, 32'(load_ready[i]), 32'd1);
      end
      start_load();
      for (int k = 0; k < 7; k++) send(jalr[k], k == 6);
      fetch(32'd6);
      chk("jalr_pc6", 0, fetch_instr[0], 32'd25165824);
      tick();
      chk("jalr_pc6", 1, fetch_instr[1], 32'd25165824);
      repeat (2) tick();
      start_load();
      for (int k = 0; k < 5; k++) send(subone[k], 1'b0);
      rst_n = 1'b0;
      #1 rst_checks();
      tick();
      rst_n = 1'b1;
      fetch_req = 1'b1; fetch_pc = 32'd1;
      repeat (10) tick();
      fetch_req = 1'b0;
      start_load();
      for (int k = 0; k < 7; k++) send(jalr[k], k == 6);
      fetch(32'd0);
      chk("reload_pc0", 0, fetch_instr[0], 32'd8454150);
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/lc2k_imem_loadable.md
Name: lc2k_imem_loadable

Overview:
Parametrised, synchronous LC2K instruction memory for the pipelined core. It replaces the hard-coded, combinational ROM.
- Programs are streamed in at run time through a valid/ready load port.
- Fetches use a request/valid handshake with configurable read latency.
- PCs outside the loaded program are flagged as faults and answered with a halt word.

Parameters:
DEPTH, 64, number of 32-bit instruction words (power of two, 8..1024)
ADDR_W, 6, log2(DEPTH); index bits taken from fetch_pc
READ_LAT, 1, fetch latency in cycles, legal values 1 or 2

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: begin (re)loading a program at word 0
load_valid  in  1  load_data is valid this cycle
load_ready  out  1  memory accepts a load word this cycle
load_data  in  32  instruction word to write
load_last  in  1  qualifies the final word of the program
prog_len  out  ADDR_W+1  number of words in the current program
running  out  1  high in RUN state
fetch_req  in  1  fetch request
fetch_ready  out  1  request accepted when fetch_req && fetch_ready
fetch_pc  in  32  word address to fetch
fetch_valid  out  1  response valid, exactly READ_LAT cycles after acceptance
fetch_instr  out  32  fetched instruction
fetch_fault  out  1  qualifies fetch_valid: PC was out of range

Behaviour:
- Reset: state=EMPTY, wr_ptr=0, prog_len=0, load_ready=0, running=0, fetch_ready=0, fetch_valid=0, fetch_instr=0, fetch_fault=0, pipeline flushed. The memory array is not reset.
- FSM states: EMPTY, LOAD, RUN, DRAIN.
  - EMPTY: load_start -> LOAD with wr_ptr=0.
  - LOAD: load_ready = (wr_ptr < DEPTH).
    - Each handshake writes mem[wr_ptr] and increments wr_ptr.
    - Handshake with load_last -> RUN, prog_len = wr_ptr+1.
    - DEPTH-th word accepted without load_last -> RUN, prog_len=DEPTH (auto-terminate).
    - load_start in LOAD restarts at wr_ptr=0; any data handshake in that same cycle is ignored.
  - RUN: running=1, fetch_ready=1. load_start -> DRAIN, and fetch_ready=0 in that same cycle, so a same-cycle fetch_req is not accepted.
  - DRAIN: fetch_ready=0. Go to LOAD (wr_ptr=0, prog_len=0) once no response is in flight; if the pipeline is already empty, LOAD follows after one cycle.
- Fetch:
  - Accepted fetches carry their address and fault flag through READ_LAT register stages.
  - Fault when fetch_pc >= prog_len, including any nonzero upper bits above ADDR_W.
  - A fault response gives fetch_instr = 32'h0180_0000 (LC2K halt) and fetch_fault=1.
  - A non-fault response gives mem[fetch_pc[ADDR_W-1:0]] and fetch_fault=0.
  - Back-to-back fetches every cycle are allowed; throughput is 1 per cycle.
  - fetch_valid is deasserted in cycles with no response. fetch_instr holds its last value then.
- Fetch requests outside RUN are ignored and produce no response.
- Reset asserted mid-load or mid-fetch: everything returns to the reset values above. In-flight responses are dropped and the program must be reloaded.
- Read-during-write cannot occur, because loading and fetching are mutually exclusive by state.

Decomposition:
- Shared package lc2k_pkg holds:
  - LC2K opcode constants (ADD..NOOP);
  - HALT_WORD = 32'h0180_0000;
  - the imem_state_t enum {EMPTY, LOAD, RUN, DRAIN}.
- One sub-module, lc2k_imem_ram: single-port synchronous RAM with a write enable and a registered read. The top level owns the FSM, the counters and the latency pipeline.

Test Plan:
- Load the 12-word subone program (first word 8454158, 11th word 25165824, last word with load_last). Expect prog_len=12 and running=1 one cycle after the last handshake. Fetch PC 0..11 back-to-back: fetch_instr matches each word READ_LAT cycles later, fetch_fault=0.
- After that program, fetch PC 12 and PC 32'h0001_0000: fetch_valid=1, fetch_fault=1, fetch_instr=32'h0180_0000.
- Stream DEPTH+3 words with load_last never asserted: load_ready drops after the DEPTH-th word, prog_len=DEPTH, running=1, the extra words are never written.
- With READ_LAT=2, issue 3 back-to-back fetches, then load_start on the cycle after the third. fetch_ready=0 immediately, all 3 responses are delivered, then state=LOAD and prog_len=0. Reload a 7-word program (the jalrTest program) and fetch PC 6 = 25165824.
- Assert rst_n=0 mid-load after 5 words: all outputs return to reset values. A fetch afterwards produces no response until a program is loaded.
- In EMPTY, hold fetch_req=1 for 10 cycles: fetch_ready=0 and fetch_valid=0 throughout.
